// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU (C) and the front-panel
// debug/loader path (D): round-robin arbitration in IDLE, strobe stretched by
// WAIT_CYCLES, registered read data and a one-cycle ack per completed access.
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          last_d_q, last_d_d;
  logic          c_ack_q, c_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [1:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          pick_dbg_c;
  logic          win_we_c;

  // State and output registers; last owner resets to D so C wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      last_d_q    <= 1'b1;
      c_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      grant_q     <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      last_d_q    <= last_d_d;
      c_ack_q     <= c_ack_d;
      d_ack_q     <= d_ack_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
    end
  end

  // Arbitration, strobe timing and completion sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    last_d_d    = last_d_q;
    c_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    c_rdata_d   = c_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    // D wins when it is alone, or on a tie when C owned the last access.
    pick_dbg_c  = d_req && (!c_req || !last_d_q);
    win_we_c    = pick_dbg_c ? d_we : c_we;

    case (state_q)
      S_IDLE: begin
        if (c_req || d_req) begin
          we_d        = win_we_c;
          mem_addr_d  = pick_dbg_c ? d_addr : c_addr;
          mem_wdata_d = pick_dbg_c ? d_wdata : c_wdata;
          grant_d     = pick_dbg_c ? 2'b10 : 2'b01;
          mem_read_d  = ~win_we_c;
          mem_write_d = win_we_c;
          cnt_d       = CW'(WAIT_CYCLES);
          busy_d      = 1'b1;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!we_q) begin
            if (grant_q[1]) begin
              d_rdata_d = mem_rdata;
            end else begin
              c_rdata_d = mem_rdata;
            end
          end
          c_ack_d = grant_q[0];
          d_ack_d = grant_q[1];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        last_d_d = grant_q[1];
        grant_d  = 2'b00;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign c_ack     = c_ack_q;
  assign d_ack     = d_ack_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 8-bit-data, 16-bit-address program/data memory between two requesters.
- Port C is the CPU datapath: AR address, read/write strobes, bus-to-memory data.
- Port D is the front-panel debug/loader path, which deposits and examines bytes while the CPU is idle or running.
- Serialises accesses, stretches memory strobes by a programmable wait count, returns read data, and signals completion with a one-cycle ack.

Parameters:
- WAIT_CYCLES, 1, extra cycles the memory strobe is held beyond the first (legal 0..15).
- AW, 16, address width.
- DW, 8, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- c_req  input  1  CPU access request; held until c_ack.
- c_we  input  1  1 = write, 0 = read; valid with c_req.
- c_addr  input  AW  CPU address.
- c_wdata  input  DW  CPU write data.
- c_ack  output  1  one-cycle completion pulse to the CPU.
- c_rdata  output  DW  CPU read data, registered.
- d_req  input  1  debug request; held until d_ack.
- d_we  input  1  debug write enable.
- d_addr  input  AW  debug address.
- d_wdata  input  DW  debug write data.
- d_ack  output  1  one-cycle completion pulse to debug.
- d_rdata  output  DW  debug read data, registered.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- grant  output  2  owner of the current access: 01 = C, 10 = D, 00 = none.
- busy  output  1  high in ACCESS or DONE.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0 immediately.
  - State returns to IDLE, the wait counter clears, and last_owner is set to D, so C wins the first tie.
  - Any access in flight is abandoned with no ack.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Only c_req: grant C.
  - Only d_req: grant D.
  - Both: round-robin; grant the port that is not last_owner.
  - On grant, in the same edge: latch we/addr/wdata of the winner into mem_addr/mem_wdata, set grant, load counter = WAIT_CYCLES, go to ACCESS.
- ACCESS:
  - mem_read = ~we_latched and mem_write = we_latched, held for WAIT_CYCLES+1 cycles.
  - mem_addr and mem_wdata stay stable throughout.
  - The counter decrements each cycle. At counter 0, strobes drop on the next edge; for a read, mem_rdata is captured into the owner's rdata register on that edge. The FSM then goes to DONE.
- DONE:
  - The owner's ack is high for exactly one cycle.
  - last_owner is updated, grant clears to 00, and the FSM returns to IDLE.
- Latency: req seen in IDLE at edge 0, strobe on cycles 1..WAIT_CYCLES+1, ack on cycle WAIT_CYCLES+2. With the default, ack is in cycle 3.
- Back-to-back accesses: IDLE lasts at least one cycle between accesses. A req still high in that IDLE cycle is re-arbitrated, so requesters drop req on the cycle after ack.
- Requests are never preempted; a request arriving during ACCESS waits.
- req dropped mid-access: the access completes and ack still pulses.
- c_rdata and d_rdata hold their value until the next read completed for that port; writes do not change them.
- mem_read and mem_write are never high together. At most one of c_ack/d_ack is high in any cycle.
- Request inputs are sampled only in IDLE. Inputs other than the winner's are ignored during ACCESS.

Test Plan:
- Reset: drive rst=0 mid-ACCESS with mem_read high -> all outputs 0 in the same cycle; after release, c_req read of 0x0010 with mem_rdata=0x5A -> c_ack in cycle 3, c_rdata=0x5A.
- Debug write: d_req, d_we=1, d_addr=0x1234, d_wdata=0xC3, WAIT_CYCLES=1 -> mem_write high exactly 2 cycles with mem_addr=0x1234 and mem_wdata=0xC3, d_ack one cycle, d_rdata unchanged.
- Simultaneous requests from reset: c_req and d_req both held -> grant sequence 01,10,01,10 across four accesses, ack alternating C/D.
- Request during ACCESS: d_req rises while C owns the bus -> C completes untouched, D is granted in the IDLE cycle after C's DONE.
- WAIT_CYCLES=0 build: single read -> mem_read high for 1 cycle, ack in cycle 2.
- WAIT_CYCLES=15 build: single read -> mem_read high for 16 cycles, ack in cycle 17.
- Request withdrawal: c_req dropped in the second ACCESS cycle -> strobe completes full length, c_ack still pulses, no new grant follows.
